// File: rtl/pin_level_driver.sv
// pin_level_driver: drives a glitch-free output pin from level-change
// requests. Every pin change is followed by a hold window of HOLD_CYCLES
// cycles during which no new request is accepted. A far-end debouncer
// therefore always sees a stable level. Each change emits a one-cycle
// H2L/L2H pulse that is coincident with the new pin level.
module pin_level_driver #(
  parameter logic IDLE_LEVEL  = 1'b1,
  parameter int   HOLD_CYCLES = 240000,
  parameter int   CNT_W       = 18
) (
  input  logic Sys_clk,
  input  logic Sys_reset,
  input  logic Req_valid,
  input  logic Req_level,
  output logic Req_ready,
  output logic Pin_out,
  output logic Busy,
  output logic H2L_Sig,
  output logic L2H_Sig
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Terminal count of the hold window. The window lasts exactly HOLD_CYCLES cycles.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pin_q;
  logic             ready_q;
  logic             busy_q;
  logic             h2l_q;
  logic             l2h_q;

  // A request only moves the pin when it asks for a different level.
  // A same-level request is simply consumed.
  logic req_change;
  assign req_change = Req_valid && (Req_level != pin_q);

  // Handshake, hold-window timing and edge pulses, all from registers.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the value from before the edge.
  always_ff @(posedge Sys_clk or negedge Sys_reset) begin
    if (!Sys_reset) begin
      // NOTE: the reset forces the pin straight back to IDLE_LEVEL, even in
      // the middle of a hold window. The pulses are cleared, so this forced
      // change is never reported as an edge.
      state_q <= IDLE;
      cnt_q   <= '0;
      pin_q   <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      h2l_q   <= 1'b0;
      l2h_q   <= 1'b0;
    end else begin
      h2l_q <= 1'b0;
      l2h_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_change) begin
            pin_q   <= Req_level;
            h2l_q   <= ~Req_level;
            l2h_q   <= Req_level;
            state_q <= HOLD;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        HOLD: begin
          // Requests stay pending here. They are picked up in the first IDLE cycle.
          if (cnt_q == HOLD_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign Req_ready = ready_q;
  assign Pin_out   = pin_q;
  assign Busy      = busy_q;
  assign H2L_Sig   = h2l_q;
  assign L2H_Sig   = l2h_q;

endmodule

// File: tb/tb_pin_level_driver.sv
// Bench for pin_level_driver with a short hold window (HOLD_CYCLES=8).
// The reference model is a timing rule. The pin changes only on accepted,
// differing requests. The block is ready again once HOLD_CYCLES edges have
// passed since the last change.
module tb_pin_level_driver;

  localparam int   HOLD  = 8;
  localparam logic IDLEL = 1'b1;

  logic clk;
  logic rst_n;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic pin_out;
  logic busy;
  logic h2l;
  logic l2h;

  int checks = 0;
  int errors = 0;

  // Model state, expressed in edge counts.
  int   n_edge;
  int   last_change;
  logic exp_pin;
  logic exp_ready;
  logic exp_h2l;
  logic exp_l2h;
  logic last_acc;

  pin_level_driver #(
    .IDLE_LEVEL (IDLEL),
    .HOLD_CYCLES(HOLD),
    .CNT_W      (4)
  ) dut (
    .Sys_clk  (clk),
    .Sys_reset(rst_n),
    .Req_valid(req_valid),
    .Req_level(req_level),
    .Req_ready(req_ready),
    .Pin_out  (pin_out),
    .Busy     (busy),
    .H2L_Sig  (h2l),
    .L2H_Sig  (l2h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Puts the model into the state it has right after reset: idle level and ready.
  task automatic model_reset();
    exp_pin     = IDLEL;
    last_change = n_edge - HOLD;
    exp_ready   = 1'b1;
    exp_h2l     = 1'b0;
    exp_l2h     = 1'b0;
    last_acc    = 1'b0;
  endtask

  // Advances one clock edge and updates the model. Returns #1 after the edge.
  task automatic cycle();
    logic acc;
    acc = req_valid && exp_ready;
    @(posedge clk);
    n_edge++;
    exp_h2l = 1'b0;
    exp_l2h = 1'b0;
    if (acc && (req_level != exp_pin)) begin
      exp_pin     = req_level;
      last_change = n_edge;
      exp_h2l     = ~req_level;
      exp_l2h     = req_level;
    end
    exp_ready = (n_edge - last_change) >= HOLD;
    last_acc  = acc;
    #1;
  endtask

  // Applies an async reset away from the clock edge and releases it on a negedge.
  task automatic do_reset();
    req_valid = 1'b0;
    req_level = IDLEL;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pin_out !== 1'b1 || req_ready !== 1'b1 || busy !== 1'b0 || h2l !== 1'b0 || l2h !== 1'b0) begin
      errors++;
      $display("FAIL reset_async pin=%b ready=%b busy=%b h2l=%b l2h=%b exp 1 1 0 0 0",
               pin_out, req_ready, busy, h2l, l2h);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_single_change();
    req_valid = 1'b1;
    req_level = 1'b0;
    cycle();
    req_valid = 1'b0;
    checks++;
    if (pin_out !== 1'b0 || h2l !== 1'b1 || l2h !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_edge pin=%b h2l=%b l2h=%b busy=%b ready=%b exp 0 1 0 1 0",
               pin_out, h2l, l2h, busy, req_ready);
    end
    for (int k = 1; k <= HOLD; k++) begin
      cycle();
      checks++;
      if (h2l !== 1'b0 || l2h !== 1'b0 || pin_out !== 1'b0 ||
          busy !== (k < HOLD) || req_ready !== (k >= HOLD)) begin
        errors++;
        $display("FAIL single_hold k=%0d pin=%b h2l=%b l2h=%b busy=%b ready=%b exp busy=%b ready=%b",
                 k, pin_out, h2l, l2h, busy, req_ready, (k < HOLD), (k >= HOLD));
      end
    end
  endtask

  task automatic test_back_to_back();
    int changes[$];
    int n_h2l;
    int n_l2h;
    logic prev_pin;
    int   sent;
    n_h2l     = 0;
    n_l2h     = 0;
    sent      = 0;
    prev_pin  = pin_out;
    req_valid = 1'b1;
    req_level = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (h2l === 1'b1) n_h2l++;
      if (l2h === 1'b1) n_l2h++;
      checks++;
      if (h2l === 1'b1 && l2h === 1'b1) begin
        errors++;
        $display("FAIL b2b_overlap cycle=%0d h2l=%b l2h=%b exp not both 1", i, h2l, l2h);
      end
      if (pin_out !== prev_pin) changes.push_back(i);
      prev_pin = pin_out;
      if (last_acc) begin
        sent++;
        if (sent == 1) req_level = 1'b1;
        else req_valid = 1'b0;
      end
    end
    checks++;
    if (changes.size() != 2) begin
      errors++;
      $display("FAIL b2b_change_count got=%0d exp=2", changes.size());
    end else begin
      checks++;
      if (changes[1] - changes[0] != HOLD + 1) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d exp=%0d", changes[1] - changes[0], HOLD + 1);
      end
    end
    checks++;
    if (n_h2l != 1 || n_l2h != 1 || pin_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_pulses h2l=%0d l2h=%0d pin=%b exp 1 1 1", n_h2l, n_l2h, pin_out);
    end
  endtask

  task automatic test_same_level();
    req_valid = 1'b1;
    req_level = 1'b1;
    cycle();
    req_valid = 1'b0;
    checks++;
    if (pin_out !== 1'b1 || h2l !== 1'b0 || l2h !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_level pin=%b h2l=%b l2h=%b busy=%b ready=%b exp 1 0 0 0 1",
               pin_out, h2l, l2h, busy, req_ready);
    end
    cycle();
    checks++;
    if (pin_out !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_level_after pin=%b busy=%b ready=%b exp 1 0 1", pin_out, busy, req_ready);
    end
  endtask

  task automatic test_reset_mid_hold();
    req_valid = 1'b1;
    req_level = 1'b0;
    cycle();
    req_valid = 1'b0;
    repeat (3) cycle();
    checks++;
    if (pin_out !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midhold_pre pin=%b busy=%b exp 0 1", pin_out, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pin_out !== 1'b1 || l2h !== 1'b0 || h2l !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midhold_async pin=%b l2h=%b h2l=%b busy=%b ready=%b exp 1 0 0 0 1",
               pin_out, l2h, h2l, busy, req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (l2h !== 1'b0 || pin_out !== 1'b1) begin
      errors++;
      $display("FAIL midhold_in_reset l2h=%b pin=%b exp 0 1", l2h, pin_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    req_valid = 1'b1;
    req_level = 1'b0;
    cycle();
    req_valid = 1'b0;
    checks++;
    if (pin_out !== 1'b0 || h2l !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midhold_first_accept pin=%b h2l=%b ready=%b exp 0 1 0", pin_out, h2l, req_ready);
    end
  endtask

  // Randomized requester that holds its level while a request is pending.
  task automatic test_random();
    int pin_changes;
    int pulses;
    logic prev_pin;
    pin_changes = 0;
    pulses      = 0;
    prev_pin    = pin_out;
    req_valid   = 1'b0;
    last_acc    = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!req_valid) begin
        if ($urandom_range(0, 1) == 1) begin
          req_valid = 1'b1;
          req_level = 1'($urandom_range(0, 1));
        end
      end else if (last_acc) begin
        if ($urandom_range(0, 2) == 0) req_valid = 1'b0;
        else req_level = 1'($urandom_range(0, 1));
      end
      cycle();
      if (pin_out !== prev_pin) pin_changes++;
      if (h2l === 1'b1 || l2h === 1'b1) pulses++;
      prev_pin = pin_out;
      checks++;
      if (pin_out !== exp_pin || req_ready !== exp_ready || busy !== ~exp_ready ||
          h2l !== exp_h2l || l2h !== exp_l2h) begin
        errors++;
        $display("FAIL random cycle=%0d pin=%b ready=%b busy=%b h2l=%b l2h=%b exp %b %b %b %b %b",
                 i, pin_out, req_ready, busy, h2l, l2h,
                 exp_pin, exp_ready, ~exp_ready, exp_h2l, exp_l2h);
      end
    end
    checks++;
    if (pulses != pin_changes || pin_changes == 0) begin
      errors++;
      $display("FAIL random_pulse_count pulses=%0d changes=%0d exp equal and nonzero",
               pulses, pin_changes);
    end
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_level = 1'b1;
    n_edge    = 0;
    model_reset();
    test_reset();
    test_single_change();
    do_reset();
    test_back_to_back();
    repeat (HOLD + 1) cycle();
    test_same_level();
    test_reset_mid_hold();
    do_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pin_level_driver.md
Name: pin_level_driver

Overview:
Transmit-side counterpart of the pin debouncer. It takes level-change requests from on-chip logic and drives a clean, glitch-free output pin. The driven level is held for at least a programmed time, so a debouncer-equipped receiver at the far end always sees a stable level. It also emits one-cycle edge pulses on H2L_Sig and L2H_Sig, using the same edge-signal semantics as the input-side detector.

Parameters:
IDLE_LEVEL, 1, pin level driven out of reset.
HOLD_CYCLES, 240000, minimum hold time in Sys_clk cycles (20 ms at 12 MHz); must be >= 2.
CNT_W, 18, hold counter width; must satisfy 2^CNT_W >= HOLD_CYCLES.

Ports:
Sys_clk  input  1  system clock, 12 MHz nominal.
Sys_reset  input  1  asynchronous reset, active-low.
Req_valid  input  1  requester has a level to drive.
Req_level  input  1  requested pin level; held stable while Req_valid=1 and not yet accepted.
Req_ready  output  1  block can accept a request this cycle.
Pin_out  output  1  driven pin level, registered.
Busy  output  1  hold window in progress.
H2L_Sig  output  1  one-cycle pulse, Pin_out went 1->0.
L2H_Sig  output  1  one-cycle pulse, Pin_out went 0->1.

Behaviour:
- All outputs are registered. No combinational path from Req_* to Pin_out.
- Reset (Sys_reset=0, asynchronous, any state):
  - Pin_out=IDLE_LEVEL, state=IDLE, counter=0.
  - Req_ready=1, Busy=0, H2L_Sig=0, L2H_Sig=0.
- Release from reset is synchronous to Sys_clk.
- Handshake: a request is accepted on a rising edge where Req_valid=1 and Req_ready=1. Req_ready=1 only in IDLE.
- State IDLE (Req_ready=1, Busy=0):
  - Accept with Req_level != Pin_out: at the next edge Pin_out<=Req_level and the matching edge pulse is high for exactly that one cycle, coincident with the new Pin_out. State->HOLD, counter<=0.
  - Accept with Req_level == Pin_out: request is consumed, no pin change, no pulse, stay in IDLE. This is legal and costs one cycle.
  - No request: hold all state.
- State HOLD (Req_ready=0, Busy=1):
  - Counter increments by 1 per cycle.
  - When counter==HOLD_CYCLES-1: state->IDLE and counter<=0 at the next edge.
  - HOLD therefore lasts exactly HOLD_CYCLES cycles after the Pin_out change.
  - Req_valid is ignored and the request stays pending.
- Minimum stable time: a request pending throughout is accepted in the first IDLE cycle. The next Pin_out change lands HOLD_CYCLES+1 cycles after the previous change, never sooner.
- Edge pulses:
  - H2L_Sig and L2H_Sig are never high simultaneously.
  - Each is never high for two consecutive cycles (guaranteed because HOLD_CYCLES >= 2).
  - Each pin change produces exactly one pulse.
- Counter: CNT_W bits unsigned. It never wraps because it is cleared on HOLD exit.
- Reset during HOLD: Pin_out returns to IDLE_LEVEL immediately, even mid-window. No edge pulse is generated for this reset-forced change. The pending request is lost, and the requester must re-present it.
- Simultaneous Req_valid and HOLD expiry: the request is not accepted on the expiry edge (Req_ready=0). It is accepted on the following IDLE cycle.
- Req_level changing while Req_valid=1 and not accepted is a requester protocol violation. The block samples Req_level only at acceptance.

Test Plan:
1. Reset values (bench HOLD_CYCLES=8, IDLE_LEVEL=1): assert Sys_reset=0 mid-cycle -> Pin_out=1, Req_ready=1, Busy=0, both pulses 0 immediately, without waiting for a clock edge.
2. Single change: from IDLE, Req_valid=1, Req_level=0 for one cycle at edge t -> at edge t+1 Pin_out=0 and H2L_Sig=1 for one cycle. Busy=1 and Req_ready=0 for 8 cycles. Req_ready=1 again at edge t+9.
3. Back-to-back: hold Req_valid=1 with Req_level=0, then 1 immediately after acceptance -> Pin_out 1->0->1, changes exactly 9 cycles apart. Exactly one H2L_Sig pulse and one L2H_Sig pulse, no overlap.
4. Same-level request: Pin_out=1, Req_level=1 accepted -> no Pin_out change, no pulse, Busy stays 0, Req_ready stays 1.
5. Reset mid-hold: after a 1->0 change, assert Sys_reset=0 at hold cycle 4 -> Pin_out=1 asynchronously, no L2H_Sig pulse. After release, a new request is accepted on the first edge.
6. Loopback: drive Pin_out into the debounce block with full defaults, then request toggles 0,1,0 with Req_valid held -> the debouncer output follows each level once, with no missed or extra transitions.
